mul_sm_seq: RTL and testbench

MUL_SM_SEQ -- requirements
Module: mul_sm_seq

---
 rtl/jpeg_mul_pkg.sv | 20 ++
 rtl/mul_pp_add.sv | 29 ++
 rtl/mul_sm_seq.sv | 140 ++++++++++++++
 tb/tb_mul_sm_seq.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_mul_pkg.sv
// Shared definitions for the sequential sign-magnitude multiplier.
// Provides the controller state encoding and the default operand widths
// used as parameter defaults by mul_sm_seq and mul_pp_add.
package jpeg_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_A_W = 31;
    localparam int DEF_B_W = 20;

    // Number of K-bit multiplier slices needed to cover a width-bit operand.
    function automatic int ceil_div(input int x, input int y);
        return (x + y - 1) / y;
    endfunction

endpackage

// File: rtl/mul_pp_add.sv
// Partial-product adder: one shift-and-add step of the sequential multiplier.
// Ports:
//   a_mag  in  A_W  unsigned multiplicand magnitude
//   slice  in  K    current K-bit slice of the multiplier
//   shift  in  32   left shift applied to the partial product (K * slice index)
//   acc    in  P_W  running unsigned accumulator
//   sum    out P_W  acc + (a_mag * slice) << shift
// Purely combinational.
module mul_pp_add
    import jpeg_mul_pkg::*;
#(
    parameter int A_W = DEF_A_W,
    parameter int K   = 1,
    parameter int P_W = DEF_A_W + DEF_B_W
) (
    input  logic [A_W-1:0] a_mag,
    input  logic [K-1:0]   slice,
    input  logic [31:0]    shift,
    input  logic [P_W-1:0] acc,
    output logic [P_W-1:0] sum
);

    logic [P_W-1:0] pp;

    // The full product fits P_W, so no partial sum can exceed it either.
    assign pp  = (P_W'(a_mag) * P_W'(slice)) << shift;
    assign sum = acc + pp;

endmodule

// File: rtl/mul_sm_seq.sv
// Sequential multiplier: two's-complement multiplicand times a
// sign-magnitude multiplier, retiring K multiplier bits per cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake
//   signed_a [A_W]        two's-complement multiplicand
//   b [B_W], sign_b       multiplier magnitude and sign (1 = negative)
//   out_valid / out_ready result handshake
//   c [A_W+B_W]           signed product, two's complement
//   busy                  high while an operation is in RUN or DONE
// Latency: out_valid rises N+1 cycles after the accepting edge
// (N accumulate cycles plus one cycle to apply the sign into c).
module mul_sm_seq
    import jpeg_mul_pkg::*;
#(
    parameter int A_W = DEF_A_W,
    parameter int B_W = DEF_B_W,
    parameter int K   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_W-1:0]       signed_a,
    input  logic [B_W-1:0]       b,
    input  logic                 sign_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [A_W+B_W-1:0]   c,
    output logic                 busy
);

    localparam int P_W   = A_W + B_W;
    localparam int N     = ceil_div(B_W, K);
    localparam int BP_W  = N * K;
    localparam int CNT_W = $clog2(N + 1);

    state_t              state_reg, state_next;
    logic [A_W-1:0]      a_mag_reg;
    logic [BP_W-1:0]     b_reg;
    logic                sign_reg;
    logic [P_W-1:0]      acc_reg;
    logic [P_W-1:0]      acc_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [P_W-1:0]      c_reg;
    logic [31:0]         shift_amt;
    logic                accept;
    logic                acc_done;

    assign accept   = in_valid && in_ready;
    assign acc_done = (cnt_reg == CNT_W'(N));

    // b_reg is shifted right as slices are consumed, so the live slice
    // always sits in the low K bits; the counter supplies the weight.
    assign shift_amt = 32'(cnt_reg) * 32'(K);

    mul_pp_add #(
        .A_W (A_W),
        .K   (K),
        .P_W (P_W)
    ) u_pp_add (
        .a_mag (a_mag_reg),
        .slice (b_reg[K-1:0]),
        .shift (shift_amt),
        .acc   (acc_reg),
        .sum   (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (acc_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Retiring the result frees the block for a same-edge capture.
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mag_reg <= '0;
            b_reg     <= '0;
            sign_reg  <= 1'b0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            c_reg     <= '0;
        end else if (accept) begin
            // Negating the most negative value wraps to 2^(A_W-1), which is
            // exactly the required unsigned magnitude.
            a_mag_reg <= signed_a[A_W-1] ? (~signed_a + A_W'(1)) : signed_a;
            b_reg     <= BP_W'(b);
            sign_reg  <= signed_a[A_W-1] ^ sign_b;
            acc_reg   <= '0;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            if (!acc_done) begin
                acc_reg <= acc_next;
                b_reg   <= b_reg >> K;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                // Negating a zero magnitude gives zero, so -0 cannot appear.
                c_reg <= sign_reg ? (~acc_reg + P_W'(1)) : acc_reg;
            end
        end
    end

    assign c = c_reg;

endmodule

// File: tb/tb_mul_sm_seq.sv
module tb_mul_sm_seq;

    localparam int A_W = 31;
    localparam int B_W = 20;
    localparam int P_W = A_W + B_W;
    localparam int N1  = 20;   // iterations at K = 1
    localparam int N4  = 5;    // iterations at K = 4

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] signed_a;
    logic [B_W-1:0] b;
    logic           sign_b;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] c;
    logic           busy;

    logic           k_in_valid;
    logic           k_in_ready;
    logic [A_W-1:0] k_signed_a;
    logic [B_W-1:0] k_b;
    logic           k_sign_b;
    logic           k_out_valid;
    logic           k_out_ready;
    logic [P_W-1:0] k_c;
    logic           k_busy;

    int checks;
    int errors;

    mul_sm_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .signed_a  (signed_a),
        .b         (b),
        .sign_b    (sign_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    mul_sm_seq #(.A_W(A_W), .B_W(B_W), .K(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (k_in_valid),
        .in_ready  (k_in_ready),
        .signed_a  (k_signed_a),
        .b         (k_b),
        .sign_b    (k_sign_b),
        .out_valid (k_out_valid),
        .out_ready (k_out_ready),
        .c         (k_c),
        .busy      (k_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed arithmetic on 64-bit integers, truncated to P_W.
    function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] bb,
                                               input logic sb);
        longint av;
        longint bv;
        longint pr;
        logic [63:0] raw;
        av  = longint'(signed'(a));
        bv  = longint'({44'd0, bb});
        pr  = av * bv;
        if (sb) pr = -pr;
        raw = pr;
        return raw[P_W-1:0];
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s in_ready timeout: got %0b want 1", name, in_ready);
        end
    endtask

    // Waits for out_valid on the default instance, returns edges counted.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Runs one full operation on the default instance and retires it.
    task automatic do_op(input logic [A_W-1:0] a, input logic [B_W-1:0] bb,
                         input logic sb, input int hold, input string name);
        logic [P_W-1:0] exp_c;
        int lat;
        exp_c = ref_mul(a, bb, sb);
        wait_ready(name);
        signed_a = a; b = bb; sign_b = sb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s run_flags: busy=%0b in_ready=%0b want 1/0", name, busy, in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat != N1 + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, N1 + 1);
        end
        checks++;
        if (c !== exp_c) begin
            errors++;
            $display("FAIL %s c: got %h want %h", name, c, exp_c);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || c !== exp_c) begin
                errors++;
                $display("FAIL %s hold: out_valid=%0b c=%h want 1/%h", name, out_valid, c, exp_c);
            end
        end
        $display("op %s a=%h b=%h sign_b=%0b c=%h exp=%h lat=%0d", name, a, bb, sb, c, exp_c, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s retire: out_valid=%0b busy=%0b want 0/0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || c !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%0b busy=%0b c=%h want 0/0/0", out_valid, busy, c);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || k_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b/%0b want 1/1", in_ready, k_in_ready);
        end
        $display("reset out_valid=%0b busy=%0b c=%h in_ready=%0b", out_valid, busy, c, in_ready);
    endtask

    task automatic test_directed;
        do_op(31'h7FFF_FFFD, 20'd5, 1'b0, 2, "neg3x5");
        do_op(31'h4000_0000, 20'hFFFFF, 1'b1, 1, "minA_maxB");
        do_op(31'd0, 20'd77, 1'b1, 1, "zero_neg");
        do_op(31'd12345, 20'd0, 1'b1, 0, "b_zero");
        do_op(31'h3FFF_FFFF, 20'hFFFFF, 1'b0, 0, "maxA_maxB");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            do_op(A_W'($urandom), B_W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "random");
        end
    endtask

    // Operands offered during RUN and stalled DONE must not be latched.
    task automatic test_ignore;
        logic [P_W-1:0] exp_c;
        int lat;
        exp_c = ref_mul(31'd1111, 20'd222, 1'b0);
        wait_ready("ignore");
        signed_a = 31'd1111; b = 20'd222; sign_b = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        signed_a = 31'd999; b = 20'd999; sign_b = 1'b1;
        wait_valid(lat);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (c !== exp_c || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ignore c: got %h valid=%0b want %h/1", c, out_valid, exp_c);
        end
        $display("op ignore c=%h exp=%h lat=%0d", c, exp_c, lat);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [P_W-1:0] exp1;
        logic [P_W-1:0] exp2;
        int lat;
        exp1 = ref_mul(31'h7FFF_F000, 20'd4321, 1'b0);
        exp2 = ref_mul(31'd777, 20'd888, 1'b1);
        wait_ready("b2b");
        signed_a = 31'h7FFF_F000; b = 20'd4321; sign_b = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(lat);
        checks++;
        if (c !== exp1) begin
            errors++;
            $display("FAIL b2b first c: got %h want %h", c, exp1);
        end
        signed_a = 31'd777; b = 20'd888; sign_b = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || c !== exp1) begin
            errors++;
            $display("FAIL b2b capture: out_valid=%0b busy=%0b c=%h want 0/1/%h", out_valid, busy, c, exp1);
        end
        wait_valid(lat);
        checks++;
        if (lat != N1 + 1 || c !== exp2) begin
            errors++;
            $display("FAIL b2b second: lat=%0d c=%h want %0d/%h", lat, c, N1 + 1, exp2);
        end
        $display("op b2b c1=%h c2=%h exp2=%h lat=%0d", exp1, c, exp2, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        do_op(31'd100, 20'd3, 1'b0, 0, "pre_reset");
        wait_ready("midrst");
        signed_a = 31'd123; b = 20'd456; sign_b = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || c !== '0) begin
            errors++;
            $display("FAIL midrun_reset: out_valid=%0b busy=%0b c=%h want 0/0/0", out_valid, busy, c);
        end
        $display("reset mid-run out_valid=%0b busy=%0b c=%h", out_valid, busy, c);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(31'd7, 20'd9, 1'b0, 0, "after_reset");
    endtask

    task automatic test_k4;
        logic [P_W-1:0] exp_c;
        int lat;
        exp_c = ref_mul(31'd1000, 20'd3, 1'b1);
        k_signed_a = 31'd1000; k_b = 20'd3; k_sign_b = 1'b1; k_in_valid = 1'b1; k_out_ready = 1'b0;
        @(posedge clk); #1;
        k_in_valid = 1'b0;
        lat = 0;
        while (!k_out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != N4 + 1 || k_c !== exp_c) begin
            errors++;
            $display("FAIL k4 result: lat=%0d c=%h want %0d/%h", lat, k_c, N4 + 1, exp_c);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (k_c !== exp_c || k_out_valid !== 1'b1 || k_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL k4 stall: c=%h valid=%0b in_ready=%0b want %h/1/0", k_c, k_out_valid, k_in_ready, exp_c);
            end
        end
        $display("op k4 a=1000 b=3 sign_b=1 c=%h exp=%h lat=%0d", k_c, exp_c, lat);
        k_out_ready = 1'b1;
        @(posedge clk); #1;
        k_out_ready = 1'b0;
        checks++;
        if (k_busy !== 1'b0 || k_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL k4 retire: busy=%0b in_ready=%0b want 0/1", k_busy, k_in_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0; signed_a = '0; b = '0; sign_b = 1'b0; out_ready = 1'b0;
        k_in_valid = 1'b0; k_signed_a = '0; k_b = '0; k_sign_b = 1'b0; k_out_ready = 1'b0;
        test_reset;
        test_directed;
        test_random;
        test_ignore;
        test_back_to_back;
        test_reset_mid_run;
        test_k4;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
